// File: rtl/maze_move_controller.sv
// Maze move controller: 2-flop key/start sync, IDLE/PLAY/WIN/LOSE FSM, one-cycle move pulse 2 cycles after key edge.
// No backpressure (edges during cooldown are dropped); `MAZE_TIMER_EN adds o_time_left and the LOSE timeout.
module maze_move_controller #(
   parameter int COOLDOWN_CYCLES = 4,
   parameter int CLOCK_FREQ      = 50000000,
   parameter int TIME_LIMIT      = 60
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start_btn,
   input  logic [3:0]  i_keys,
   input  logic        i_at_end,
   output logic [3:0]  o_player_direction,
   output logic        o_at_start,
   output logic        o_stop_player,
   output logic [15:0] o_move_count,
   output logic [1:0]  o_state_code
`ifdef MAZE_TIMER_EN
   ,
   output logic [7:0]  o_time_left
`endif
);
   localparam int CW = (COOLDOWN_CYCLES < 1) ? 1 : $clog2(COOLDOWN_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_WIN  = 2'b10,
      S_LOSE = 2'b11
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_key_s1, r_key_s2, r_key_s3;
   logic          r_start_s1, r_start_s2, r_start_s3;
   logic          r_at_end;
   logic [CW-1:0] r_cooldown;
   logic [3:0]    r_dir;
   logic          r_at_start;
   logic          r_stop;
   logic [15:0]   r_count;
   logic [3:0]    w_key_edge;
   logic          w_start_edge;
   logic          w_one_edge;
   logic          w_issue;
   logic          w_game_start;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_key_s1   <= 4'b0000;
         r_key_s2   <= 4'b0000;
         r_key_s3   <= 4'b0000;
         r_start_s1 <= 1'b0;
         r_start_s2 <= 1'b0;
         r_start_s3 <= 1'b0;
         r_at_end   <= 1'b0;
      end else begin
         r_key_s1   <= i_keys;
         r_key_s2   <= r_key_s1;
         r_key_s3   <= r_key_s2;
         r_start_s1 <= i_start_btn;
         r_start_s2 <= r_start_s1;
         r_start_s3 <= r_start_s2;
         r_at_end   <= i_at_end;
      end
   end

   assign w_key_edge   = r_key_s2 & ~r_key_s3;
   assign w_start_edge = r_start_s2 & ~r_start_s3;
   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign w_one_edge   = (w_key_edge != 4'b0000) && ((w_key_edge & (w_key_edge - 4'd1)) == 4'b0000);

`ifdef MAZE_TIMER_EN
   localparam int PW = (CLOCK_FREQ < 2) ? 1 : $clog2(CLOCK_FREQ);

   logic [PW-1:0] r_prescale;
   logic [7:0]    r_time_left;
   logic          w_tick;
   logic          w_timeout;

   assign w_tick    = (r_prescale == PW'(CLOCK_FREQ - 1));
   // Timeout fires in the cycle whose tick takes the counter to zero.
   assign w_timeout = (r_time_left == 8'd0) || (w_tick && (r_time_left == 8'd1));

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_prescale  <= '0;
         r_time_left <= 8'd0;
      end else if (w_game_start) begin
         r_prescale  <= '0;
         r_time_left <= TIME_LIMIT[7:0];
      end else if (r_state == S_PLAY) begin
         if (w_tick) begin
            r_prescale <= '0;
            if (r_time_left != 8'd0) r_time_left <= r_time_left - 8'd1;
         end else begin
            r_prescale <= r_prescale + PW'(1);
         end
      end
   end

   assign o_time_left = r_time_left;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{CLOCK_FREQ, TIME_LIMIT};
`endif

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_start_edge) w_next = S_PLAY;
         S_PLAY: begin
            if (r_at_end) w_next = S_WIN;
`ifdef MAZE_TIMER_EN
            else if (w_timeout) w_next = S_LOSE;
`endif
         end
         default: if (w_start_edge) w_next = S_IDLE;
      endcase
   end

   assign w_game_start = (r_state == S_IDLE) && (w_next == S_PLAY);
   assign w_issue      = (r_state == S_PLAY) && (w_next == S_PLAY) &&
                         (r_cooldown == '0) && w_one_edge;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_dir      <= 4'b0000;
         r_at_start <= 1'b1;
         r_stop     <= 1'b1;
         r_count    <= 16'd0;
         r_cooldown <= '0;
      end else begin
         r_dir      <= w_issue ? w_key_edge : 4'b0000;
         r_at_start <= (w_next == S_IDLE);
         r_stop     <= (w_next != S_PLAY);
         if (w_issue)                r_cooldown <= CW'(COOLDOWN_CYCLES);
         else if (r_cooldown != '0)  r_cooldown <= r_cooldown - CW'(1);
         if (w_game_start)                        r_count <= 16'd0;
         else if (w_issue && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      end
   end

   assign o_player_direction = r_dir;
   assign o_at_start         = r_at_start;
   assign o_stop_player      = r_stop;
   assign o_move_count       = r_count;
   assign o_state_code       = r_state;
endmodule

// File: tb/tb_maze_move_controller.sv
// Directed bench for maze_move_controller: per-cycle compare against an input-history game model,
// plus hand-computed checkpoints. Timer scenario runs when MAZE_TIMER_EN is defined.
`timescale 1ns/1ps
module tb_maze_move_controller;
   localparam int CD = 4;
   localparam int CF = 10;
   localparam int TL = 2;
   localparam int HN = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        at_end = 1'b0;
   logic [3:0]  keys = 4'b0000;
   logic [3:0]  dir;
   logic        at_start_o;
   logic        stop_o;
   logic [15:0] cnt_o;
   logic [1:0]  code_o;
`ifdef MAZE_TIMER_EN
   logic [7:0]  tl_o;
`endif

   maze_move_controller #(.COOLDOWN_CYCLES(CD), .CLOCK_FREQ(CF), .TIME_LIMIT(TL)) dut (
      .i_clock(clk), .i_reset(rst), .i_start_btn(start), .i_keys(keys), .i_at_end(at_end),
      .o_player_direction(dir), .o_at_start(at_start_o), .o_stop_player(stop_o),
      .o_move_count(cnt_o), .o_state_code(code_o)
`ifdef MAZE_TIMER_EN
      , .o_time_left(tl_o)
`endif
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Game model driven by the recorded input history of each rising edge.
   bit [3:0] h_keys [HN];
   bit       h_start[HN];
   bit       h_ae   [HN];
   int       cyc = 0;
   int       base = 0;
   int       m_state, m_cnt, m_last, m_tl, m_pc;
   bit [3:0] m_dir;

   function automatic bit [3:0] hk(input int k);
      return (k < base || k >= HN) ? 4'b0000 : h_keys[k];
   endfunction
   function automatic bit hs(input int k);
      return (k < base || k >= HN) ? 1'b0 : h_start[k];
   endfunction
   function automatic bit ha(input int k);
      return (k < base || k >= HN) ? 1'b0 : h_ae[k];
   endfunction

   task automatic m_reset();
      m_state = 0; m_cnt = 0; m_last = -1000; m_dir = 4'b0000; m_tl = 0; m_pc = 0;
   endtask

   task automatic m_step(input int k);
      bit [3:0] kn;
      bit       se;
      bit       ae;
      kn = hk(k - 2) & ~hk(k - 3);
      se = hs(k - 2) && !hs(k - 3);
      ae = ha(k - 1);
      m_dir = 4'b0000;
      case (m_state)
         0: if (se) begin m_state = 1; m_cnt = 0; m_tl = TL; m_pc = 0; end
         1: begin
            m_pc++;
            if (m_pc == CF) begin m_pc = 0; if (m_tl > 0) m_tl--; end
            if (ae) m_state = 2;
`ifdef MAZE_TIMER_EN
            else if (m_tl == 0) m_state = 3;
`endif
            else if ($countones(kn) == 1 && (k - m_last) > CD) begin
               m_dir = kn; m_last = k;
               if (m_cnt < 65535) m_cnt++;
            end
         end
         default: if (se) m_state = 0;
      endcase
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk);
         if (rst) begin
            m_reset();
            base = cyc + 1;
         end else begin
            if (cyc < HN) begin h_keys[cyc] = keys; h_start[cyc] = start; h_ae[cyc] = at_end; end
            m_step(cyc);
         end
         cyc++;
         @(negedge clk);
         if (rst) m_reset();
         check("state_code", int'(code_o), m_state);
         check("at_start", int'(at_start_o), int'(m_state == 0));
         check("stop_player", int'(stop_o), int'(m_state != 1));
         check("move_count", int'(cnt_o), m_cnt);
         check("player_direction", int'(dir), int'(m_dir));
`ifdef MAZE_TIMER_EN
         check("time_left", int'(tl_o), m_tl);
`endif
      end
   end

   int       pulses = 0;
   bit [3:0] last_dir = 4'b0000;
   initial forever begin
      @(negedge clk);
      if (dir != 4'b0000) begin pulses++; last_dir = dir; end
   end

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask
   task automatic sample();
      @(negedge clk); #1;
   endtask
   task automatic start_pulse();
      start = 1'b1; cycles(1); start = 1'b0; cycles(4);
   endtask

   initial begin
      cycles(3);
      sample();
      check("rst_code", int'(code_o), 0);
      check("rst_at_start", int'(at_start_o), 1);
      check("rst_stop", int'(stop_o), 1);
      check("rst_count", int'(cnt_o), 0);
      check("rst_dir", int'(dir), 0);
      rst = 1'b0; cycles(2);

      start_pulse();
      sample();
      check("play_code", int'(code_o), 1);
      check("play_at_start", int'(at_start_o), 0);
      check("play_stop", int'(stop_o), 0);
      check("play_count", int'(cnt_o), 0);

      pulses = 0;
      keys = 4'b0100; cycles(10); keys = 4'b0000; cycles(3);
      sample();
      check("hold_pulses", pulses, 1);
      check("hold_dir", int'(last_dir), 4);
      check("hold_count", int'(cnt_o), 1);

      cycles(6);
      pulses = 0;
      keys = 4'b0001; cycles(1); keys = 4'b0000; cycles(1);
      keys = 4'b0001; cycles(1); keys = 4'b0000; cycles(3);
      keys = 4'b0001; cycles(1); keys = 4'b0000; cycles(4);
      sample();
      check("cooldown_pulses", pulses, 2);
      check("cooldown_dir", int'(last_dir), 1);
      check("cooldown_count", int'(cnt_o), 3);

      cycles(6);
      pulses = 0;
      keys = 4'b0011; cycles(2); keys = 4'b0000; cycles(3);
      sample();
      check("multi_pulses", pulses, 0);
      check("multi_count", int'(cnt_o), 3);
      at_end = 1'b1; cycles(3); at_end = 1'b0;
      sample();
      check("win_code", int'(code_o), 2);
      check("win_stop", int'(stop_o), 1);

      start_pulse();
      sample();
      check("restart_code", int'(code_o), 0);
      check("restart_at_start", int'(at_start_o), 1);

      start_pulse();
      start_pulse();
      sample();
      check("start_ignored_code", int'(code_o), 1);
      check("newgame_count", int'(cnt_o), 0);

      cycles(6);
      pulses = 0;
      keys = 4'b0100; cycles(1); at_end = 1'b1; cycles(1); keys = 4'b0000; cycles(3); at_end = 1'b0;
      sample();
      check("end_vs_key_pulses", pulses, 0);
      check("end_vs_key_code", int'(code_o), 2);
      check("end_vs_key_count", int'(cnt_o), 0);

      start_pulse();
      start_pulse();
      cycles(6);
      pulses = 0;
      keys = 4'b1000; cycles(1); keys = 4'b0000; cycles(1);
      rst = 1'b1; cycles(2);
      sample();
      check("abort_pulses", pulses, 0);
      check("abort_code", int'(code_o), 0);
      check("abort_at_start", int'(at_start_o), 1);
      rst = 1'b0; cycles(2);

`ifdef MAZE_TIMER_EN
      start_pulse();
      cycles(20);
      sample();
      check("timeout_code", int'(code_o), 3);
      check("timeout_left", int'(tl_o), 0);
      check("timeout_stop", int'(stop_o), 1);
      start_pulse();
      sample();
      check("lose_restart_code", int'(code_o), 0);
      check("lose_restart_at_start", int'(at_start_o), 1);
`endif

      cycles(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end
endmodule

// File: doc/maze_move_controller.md
MAZE_MOVE_CONTROLLER -- requirements
Module: maze_move_controller

Interface
REQ-001 Parameter COOLDOWN_CYCLES, default 4, meaning minimum clock cycles between two issued moves.
REQ-002 Parameter CLOCK_FREQ, default 50000000, meaning clock cycles per timer second.
REQ-003 Parameter TIME_LIMIT, default 60, meaning play time in seconds (8-bit range).
REQ-004 clock  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start_btn  input  1  start/restart request, level from debounced key.
REQ-007 keys  input  4  direction keys, level; bit0 up, bit1 down, bit2 right, bit3 left.
REQ-008 at_end  input  1  goal-reached flag from player-position datapath.
REQ-009 player_direction  output  4  one-hot move command to datapath, else 4'b0000.
REQ-010 at_start  output  1  holds datapath at origin.
REQ-011 stop_player  output  1  freezes datapath movement.
REQ-012 move_count  output  16  moves issued this game.
REQ-013 state_code  output  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.

Function
REQ-014 Keys and start_btn SHALL each pass through two flops; rising edge = second stage high, previous sample low.
REQ-015 States SHALL be IDLE, PLAY, WIN, LOSE; outputs registered, all Moore except player_direction.
REQ-016 IDLE: at_start=1, stop_player=1; start_btn edge -> PLAY, move_count cleared to 0.
REQ-017 PLAY: at_start=0, stop_player=0; registered at_end high -> WIN.
REQ-018 WIN/LOSE: at_start=0, stop_player=1, no moves; start_btn edge -> IDLE.
REQ-019 In PLAY, cooldown zero, exactly one key edge in a cycle SHALL set player_direction to that one-hot value for exactly one cycle, then 4'b0000.
REQ-020 Two or more simultaneous key edges SHALL be discarded; no move, no count.
REQ-021 Key edges during cooldown SHALL be discarded, not queued.
REQ-022 Issuing a move SHALL load cooldown with COOLDOWN_CYCLES; decrement by 1 per cycle to 0.
REQ-023 Latency: key first sampled high at edge N -> player_direction pulse after edge N+2.
REQ-024 move_count SHALL increment per issued pulse, saturating at 16'hFFFF.
REQ-025 at_end SHALL be sampled through one flop; key edge in same cycle as registered at_end high: WIN taken, no pulse.
REQ-026 start_btn edge in PLAY SHALL be ignored.

Reset
REQ-027 On reset: state IDLE, player_direction 0, at_start 1, stop_player 1, move_count 0, state_code 00, cooldown 0, sync flops 0.
REQ-028 Reset mid-PLAY SHALL abort the game immediately; no pulse emitted after reset assertion.

Configuration
REQ-029 Macro MAZE_TIMER_EN defined: output time_left (8-bit) exists, loaded TIME_LIMIT on IDLE->PLAY, decremented once per CLOCK_FREQ cycles in PLAY, frozen elsewhere, reset to 0.
REQ-030 With MAZE_TIMER_EN: time_left reaching 0 in PLAY -> LOSE; timeout and registered at_end in same cycle -> WIN.
REQ-031 Without MAZE_TIMER_EN: no time_left port, no prescaler logic, LOSE unreachable, state_code never 11.

Verification
REQ-032 Reset, then start_btn pulse -> state_code 01, at_start 0, stop_player 0, move_count 0.
REQ-033 PLAY, keys=4'b0100 held 10 cycles -> one 1-cycle pulse 4'b0100, move_count 1.
REQ-034 COOLDOWN_CYCLES=4, up key edges 2 cycles apart -> second discarded; edge 6 cycles later -> pulse 4'b0001.
REQ-035 keys 4'b0011 rising together -> no pulse, move_count unchanged; at_end high -> state_code 10, stop_player 1.
REQ-036 MAZE_TIMER_EN, CLOCK_FREQ=10, TIME_LIMIT=2 -> LOSE (11) after 20 PLAY cycles; start edge -> IDLE, at_start 1.
